c2c_link_arbiter: RTL and testbench
===================================

# c2c_link_arbiter

Master-side sequencer for the chip-to-chip link. It shares the single 3-bit request/ack/valid link between four local requesters using round-robin arbitration. For each granted transfer it runs the full handshake toward the slave chip and reports completion or timeout to the winning requester. It sits between the master's local control logic and the board-level link pins, opposite the slave controller.

## Interface
- TIMEOUT, 28'd150_000_000: cycles allowed in each of REQ and SEND before the transfer is aborted (1.5 s at 100 MHz).
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  per-requester transfer request; level, held until `grant` pulse or `timeout_err` pulse for that requester.
- req_data  input  12  requester i data on bits [3i+2:3i]; sampled only at arbitration.
- grant  output  4  one-hot one-cycle pulse to the requester whose transfer completed.
- timeout_err  output  4  one-hot one-cycle pulse to the requester whose transfer was aborted.
- busy  output  1  high in every state except IDLE.
- link_request  output  1  request to slave.
- link_ack  input  1  ack from slave, asynchronous to clk.
- link_data  output  3  data to slave.
- link_valid  output  1  data-valid to slave.

## Operation
- link_ack passes through a 2-flop synchronizer to give ack_s; only ack_s is used internally.
- Registered outputs. Reset values: grant=0, timeout_err=0, busy=0, link_request=0, link_data=0, link_valid=0; internal state=IDLE, rr_ptr=0, owner=0, timer=0, sync flops=0.
- States:
  - IDLE: if any req bit is set, pick the winner by searching i = rr_ptr, rr_ptr+1, … (mod 4). Latch owner=winner and link_data=req_data[winner]. Clear timer and go to REQ. If no req bit is set, stay.
  - REQ: link_request=1; link_data is held stable. On ack_s=1, drop link_request, clear timer and go to SEND. On timer==TIMEOUT-1, go to ABORT.
  - SEND: link_valid=1, link_request=0. On ack_s=0, go to DONE. On timer==TIMEOUT-1, go to ABORT.
  - DONE: link_valid=0, link_data=0, grant[owner]=1 for one cycle, rr_ptr=owner+1 (2-bit wrap), then IDLE.
  - ABORT: link_request=0, link_valid=0, link_data=0, timeout_err[owner]=1 for one cycle, rr_ptr=owner+1, then IDLE.
- Timer is 28-bit. It increments every cycle in REQ/SEND, clears on state entry, and saturates (never wraps).
- A requester that drops req mid-transfer does not affect the transfer. The transfer completes and its grant pulse is still issued.
- ack_s already high on entering REQ (stale ack): treated as a valid ack, so the block goes to SEND next cycle.
- Asynchronous reset at any point returns immediately to reset values. link_request and link_valid drop without waiting for the clock.
- Only one transfer is in flight at a time. req changes outside IDLE are ignored until the next arbitration.

## Timing
- Arbitration latency: req seen in IDLE at edge N gives link_request=1 and link_data valid after edge N+1.
- Ack latency: link_ack rising becomes ack_s after 2 edges. The SEND transition and link_valid=1 follow at the 3rd edge.
- Release latency: link_ack falling, then 2 edges to ack_s=0, then DONE after the 3rd edge. grant pulses during the DONE cycle. IDLE is re-entered on the 4th edge.
- Minimum IDLE-to-IDLE turnaround, excluding slave delay: 1 + 3 + 3 + 1 cycles.
- Back-to-back: the next arbitration happens in the first IDLE cycle after DONE/ABORT, so there is one cycle with busy=0 between transfers.
- Timeout: exactly TIMEOUT cycles spent in REQ or SEND, then one ABORT cycle.

## Test plan
- Setup: TIMEOUT=100 for all cases except the last.
- Single transfer: req=4'b0100, req_data[8:6]=3'b101; slave model acks 20 cycles after link_request and drops ack 5 cycles after link_valid. Required: link_data=101 through REQ/SEND, link_valid high until ack_s falls, grant=4'b0100 for one cycle, busy=0 afterwards.
- Round-robin: req=4'b1111 held, data i=i+1. Required: grant order 0,1,2,3,0 and link_data sequence 1,2,3,4,1.
- Timeout in REQ: slave never acks. Required: link_request high for exactly 100 cycles, timeout_err[owner] pulse, rr_ptr advanced, next requester served.
- Timeout in SEND: ack rises then never falls. Required: link_valid high for 100 cycles, then ABORT with timeout_err pulse and link_valid=0.
- Asynchronous reset mid-SEND: assert rst_n=0 between edges. Required: link_valid and link_request 0 immediately, busy=0, rr_ptr=0. After release, a single req=4'b0010 gets arbitrated normally.
- Stale ack: link_ack held high before req=4'b0001. Required: REQ lasts 1 cycle after sync, then SEND. Transfer completes once ack drops.

Source files
------------

// File: rtl/c2c_link_arbiter.sv
// c2c_link_arbiter: master-side sequencer for the chip-to-chip link.
// Four local requesters share one request/ack/valid link through round-robin
// arbitration. Each granted transfer runs the full four-phase handshake
// toward the slave and ends with a one-cycle grant (completion) or
// timeout_err (abort) pulse to the winning requester.
//
// Handshake contract: a requester holds req high (with stable req_data) until
// it sees its grant or timeout_err pulse. On the link, link_request rises with
// link_data valid and stays up until the synchronized ack is seen; link_valid
// then stays up until the synchronized ack falls again. link_data is constant
// from arbitration until the transfer ends.
`timescale 1ns/1ps

module c2c_link_arbiter #(
  parameter logic [27:0] TIMEOUT = 28'd150_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [11:0] req_data,
  output logic [3:0]  grant,
  output logic [3:0]  timeout_err,
  output logic        busy,
  output logic        link_request,
  input  logic        link_ack,
  output logic [2:0]  link_data,
  output logic        link_valid,
  output logic [2:0]  dbg_state,
  output logic [1:0]  dbg_rr_ptr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_SEND  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t      r_state;
  logic [1:0]  r_rr_ptr;
  logic [1:0]  r_owner;
  logic [27:0] r_timer;
  logic        r_ack_meta;
  logic        r_ack_s;
  logic [3:0]  r_grant;
  logic [3:0]  r_timeout_err;
  logic        r_busy;
  logic        r_link_request;
  logic [2:0]  r_link_data;
  logic        r_link_valid;

  logic        w_found;
  logic [1:0]  w_winner;
  logic [1:0]  w_idx;
  logic [2:0]  w_data;
  logic [3:0]  w_owner_1h;
  logic        w_timer_exp;
  logic [27:0] w_timer_next;

  // Bring the asynchronous slave ack into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
    end else begin
      r_ack_meta <= link_ack;
      r_ack_s    <= r_ack_meta;
    end
  end

  // Round-robin search: the first requester at or after r_rr_ptr wins.
  // Walking from the far end lets the nearest hit overwrite the others.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    w_idx    = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_rr_ptr + 2'(k);
      if (req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Data field of the winning requester.
  always_comb begin
    w_data = req_data[2:0];
    case (w_winner)
      2'd0: w_data = req_data[2:0];
      2'd1: w_data = req_data[5:3];
      2'd2: w_data = req_data[8:6];
      2'd3: w_data = req_data[11:9];
      default: w_data = req_data[2:0];
    endcase
  end

  assign w_owner_1h   = 4'b0001 << r_owner;
  assign w_timer_exp  = (r_timer == (TIMEOUT - 28'd1));
  assign w_timer_next = (r_timer == 28'hFFF_FFFF) ? r_timer : r_timer + 28'd1;

  // Transfer sequencer; every link and requester output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= 2'd0;
      r_owner        <= 2'd0;
      r_timer        <= 28'd0;
      r_grant        <= 4'd0;
      r_timeout_err  <= 4'd0;
      r_busy         <= 1'b0;
      r_link_request <= 1'b0;
      r_link_data    <= 3'd0;
      r_link_valid   <= 1'b0;
    end else begin
      r_grant       <= 4'd0;
      r_timeout_err <= 4'd0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner        <= w_winner;
            r_link_data    <= w_data;
            r_timer        <= 28'd0;
            r_link_request <= 1'b1;
            r_busy         <= 1'b1;
            r_state        <= S_REQ;
          end
        end
        S_REQ: begin
          if (r_ack_s) begin
            r_link_request <= 1'b0;
            r_link_valid   <= 1'b1;
            r_timer        <= 28'd0;
            r_state        <= S_SEND;
          end else if (w_timer_exp) begin
            r_link_request <= 1'b0;
            r_link_data    <= 3'd0;
            r_timeout_err  <= w_owner_1h;
            r_state        <= S_ABORT;
          end else begin
            r_timer <= w_timer_next;
          end
        end
        S_SEND: begin
          if (!r_ack_s) begin
            r_link_valid <= 1'b0;
            r_link_data  <= 3'd0;
            r_grant      <= w_owner_1h;
            r_state      <= S_DONE;
          end else if (w_timer_exp) begin
            r_link_valid  <= 1'b0;
            r_link_data   <= 3'd0;
            r_timeout_err <= w_owner_1h;
            r_state       <= S_ABORT;
          end else begin
            r_timer <= w_timer_next;
          end
        end
        S_DONE, S_ABORT: begin
          r_rr_ptr <= r_owner + 2'd1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_link_request <= 1'b0;
          r_link_valid   <= 1'b0;
          r_link_data    <= 3'd0;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

  assign grant        = r_grant;
  assign timeout_err  = r_timeout_err;
  assign busy         = r_busy;
  assign link_request = r_link_request;
  assign link_data    = r_link_data;
  assign link_valid   = r_link_valid;
  assign dbg_state    = r_state;
  assign dbg_rr_ptr   = r_rr_ptr;

endmodule

// File: tb/tb_c2c_link_arbiter.sv
// Bench for c2c_link_arbiter: directed scenarios plus randomized transfers,
// with the round-robin winner and data predicted by a small queue-free model.
`timescale 1ns/1ps

module tb_c2c_link_arbiter;

  localparam logic [27:0] TMO = 28'd100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] req_data;
  logic        link_ack;
  logic [3:0]  grant;
  logic [3:0]  timeout_err;
  logic        busy;
  logic        link_request;
  logic [2:0]  link_data;
  logic        link_valid;
  logic [2:0]  dbg_state;
  logic [1:0]  dbg_rr_ptr;

  int n_checks = 0;
  int n_pass   = 0;
  int m_rr     = 0;

  c2c_link_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .grant(grant), .timeout_err(timeout_err), .busy(busy),
    .link_request(link_request), .link_ack(link_ack), .link_data(link_data),
    .link_valid(link_valid), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: first set requester at or after the pointer, circularly
  function automatic int pick_winner(input logic [3:0] r, input int ptr);
    for (int k = 0; k < 4; k++)
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    return 0;
  endfunction

  function automatic logic [2:0] field(input logic [11:0] d, input int i);
    logic [11:0] t;
    t = d >> (3 * i);
    return t[2:0];
  endfunction

  // driver: reset with link idle
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 4'd0; link_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_rr = 0;
  endtask

  // driver: acts as slave for one complete transfer and reports what it saw
  task automatic run_xfer(input int ack_dly, input int drop_dly, input bit drop_req,
                          output int arb_lat, output logic [2:0] d_req, output bit d_stable,
                          output int ack_lat, output int rel_lat, output logic [2:0] d_done,
                          output logic [3:0] g, output bit g_once, output bit idle_after);
    arb_lat = 0;
    do begin @(negedge clk); arb_lat++; end
    while (link_request !== 1'b1 && arb_lat < 50);
    d_req = link_data; d_stable = 1'b1;
    if (drop_req) req = 4'd0;
    repeat (ack_dly) begin
      @(negedge clk);
      if (link_data !== d_req || link_request !== 1'b1) d_stable = 1'b0;
    end
    link_ack = 1'b1; ack_lat = 0;
    do begin
      @(negedge clk); ack_lat++;
      if (link_data !== d_req) d_stable = 1'b0;
    end while (link_valid !== 1'b1 && ack_lat < 50);
    repeat (drop_dly) begin
      @(negedge clk);
      if (link_valid !== 1'b1 || link_data !== d_req) d_stable = 1'b0;
    end
    link_ack = 1'b0; rel_lat = 0;
    do begin @(negedge clk); rel_lat++; end
    while (link_valid !== 1'b0 && rel_lat < 50);
    d_done = link_data;
    g = grant;
    @(negedge clk);
    g_once = (grant === 4'd0);
    idle_after = (busy === 1'b0);
  endtask

  int a_lat, k_lat, r_lat;
  logic [2:0] d_r, d_d;
  bit d_ok, g1, idl;
  logic [3:0] g_obs;

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 4'd0; link_ack = 1'b0; req_data = 12'd0;
    repeat (2) @(negedge clk);
    n_checks++; if (grant !== 4'd0) $display("FAIL rst_grant: got %b expected 0000", grant); else n_pass++;
    n_checks++; if (timeout_err !== 4'd0) $display("FAIL rst_tmo: got %b expected 0000", timeout_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (link_request !== 1'b0) $display("FAIL rst_lreq: got %b expected 0", link_request); else n_pass++;
    n_checks++; if (link_valid !== 1'b0) $display("FAIL rst_lvalid: got %b expected 0", link_valid); else n_pass++;
    n_checks++; if (link_data !== 3'd0) $display("FAIL rst_ldata: got %b expected 000", link_data); else n_pass++;
    n_checks++; if (dbg_rr_ptr !== 2'd0) $display("FAIL rst_rrptr: got %0d expected 0", dbg_rr_ptr); else n_pass++;
    rst_n = 1'b1; m_rr = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || link_request !== 1'b0) $display("FAIL idle_no_req: got busy=%b lreq=%b expected 0 0", busy, link_request); else n_pass++;
  endtask

  task automatic test_single();
    apply_reset();
    req_data = {3'($urandom_range(0, 7)), 3'b101, 6'($urandom_range(0, 63))};
    req = 4'b0100;
    run_xfer(20, 5, 1'b0, a_lat, d_r, d_ok, k_lat, r_lat, d_d, g_obs, g1, idl);
    req = 4'd0;
    n_checks++; if (a_lat !== 1) $display("FAIL single_arb_lat: got %0d expected 1", a_lat); else n_pass++;
    n_checks++; if (d_r !== 3'b101) $display("FAIL single_data: got %b expected 101", d_r); else n_pass++;
    n_checks++; if (d_ok !== 1'b1) $display("FAIL single_stable: got %b expected 1", d_ok); else n_pass++;
    n_checks++; if (k_lat !== 3) $display("FAIL single_ack_lat: got %0d expected 3", k_lat); else n_pass++;
    n_checks++; if (r_lat !== 3) $display("FAIL single_rel_lat: got %0d expected 3", r_lat); else n_pass++;
    n_checks++; if (d_d !== 3'd0) $display("FAIL single_data_clr: got %b expected 000", d_d); else n_pass++;
    n_checks++; if (g_obs !== 4'b0100) $display("FAIL single_grant: got %b expected 0100", g_obs); else n_pass++;
    n_checks++; if (g1 !== 1'b1) $display("FAIL single_grant_once: got %b expected 1", g1); else n_pass++;
    n_checks++; if (idl !== 1'b1) $display("FAIL single_busy_after: got %b expected 1", idl); else n_pass++;
  endtask

  task automatic test_round_robin();
    int w;
    logic [3:0] e;
    apply_reset();
    req_data = {3'd4, 3'd3, 3'd2, 3'd1};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      w = pick_winner(req, m_rr);
      e = 4'b0001 << w;
      run_xfer($urandom_range(0, 4), $urandom_range(0, 3), 1'b0, a_lat, d_r, d_ok, k_lat, r_lat, d_d, g_obs, g1, idl);
      n_checks++; if (g_obs !== e) $display("FAIL rr_grant[%0d]: got %b expected %b", i, g_obs, e); else n_pass++;
      n_checks++; if (d_r !== 3'(w + 1)) $display("FAIL rr_data[%0d]: got %0d expected %0d", i, d_r, w + 1); else n_pass++;
      n_checks++; if (idl !== 1'b1) $display("FAIL rr_gap[%0d]: got %b expected 1", i, idl); else n_pass++;
      m_rr = (w + 1) % 4;
    end
    req = 4'd0;
  endtask

  task automatic test_timeout_req();
    int cnt;
    apply_reset();
    req_data = {3'd6, 3'd5, 3'd2, 3'd7};
    req = 4'b0011;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (link_request !== 1'b1 && cnt < 50);
    cnt = 0;
    while (link_request === 1'b1 && cnt < 300) begin cnt++; @(negedge clk); end
    n_checks++; if (cnt !== 100) $display("FAIL treq_len: got %0d expected 100", cnt); else n_pass++;
    n_checks++; if (timeout_err !== 4'b0001) $display("FAIL treq_err: got %b expected 0001", timeout_err); else n_pass++;
    @(negedge clk);
    n_checks++; if (timeout_err !== 4'd0) $display("FAIL treq_err_once: got %b expected 0000", timeout_err); else n_pass++;
    n_checks++; if (dbg_rr_ptr !== 2'd1) $display("FAIL treq_rrptr: got %0d expected 1", dbg_rr_ptr); else n_pass++;
    m_rr = 1;
    run_xfer(3, 2, 1'b0, a_lat, d_r, d_ok, k_lat, r_lat, d_d, g_obs, g1, idl);
    n_checks++; if (g_obs !== 4'b0010) $display("FAIL treq_next_grant: got %b expected 0010", g_obs); else n_pass++;
    n_checks++; if (d_r !== 3'd2) $display("FAIL treq_next_data: got %0d expected 2", d_r); else n_pass++;
    req = 4'd0;
  endtask

  task automatic test_timeout_send();
    int cnt;
    apply_reset();
    req_data = 12'h1C0;
    req = 4'b0100;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (link_request !== 1'b1 && cnt < 50);
    link_ack = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (link_valid !== 1'b1 && cnt < 50);
    cnt = 0;
    while (link_valid === 1'b1 && cnt < 300) begin cnt++; @(negedge clk); end
    n_checks++; if (cnt !== 100) $display("FAIL tsend_len: got %0d expected 100", cnt); else n_pass++;
    n_checks++; if (timeout_err !== 4'b0100) $display("FAIL tsend_err: got %b expected 0100", timeout_err); else n_pass++;
    n_checks++; if (grant !== 4'd0 || link_data !== 3'd0) $display("FAIL tsend_clean: got grant=%b data=%b expected 0000 000", grant, link_data); else n_pass++;
    link_ack = 1'b0; req = 4'd0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int cnt;
    apply_reset();
    req_data = 12'b000_010_110_011;
    req = 4'b0001;
    run_xfer(2, 2, 1'b0, a_lat, d_r, d_ok, k_lat, r_lat, d_d, g_obs, g1, idl);
    n_checks++; if (g_obs !== 4'b0001) $display("FAIL areset_pre_grant: got %b expected 0001", g_obs); else n_pass++;
    req = 4'b0100;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (link_request !== 1'b1 && cnt < 50);
    link_ack = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (link_valid !== 1'b1 && cnt < 50);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (link_valid !== 1'b0 || link_request !== 1'b0) $display("FAIL areset_link: got valid=%b req=%b expected 0 0", link_valid, link_request); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL areset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (dbg_rr_ptr !== 2'd0) $display("FAIL areset_rrptr: got %0d expected 0", dbg_rr_ptr); else n_pass++;
    link_ack = 1'b0; req = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; m_rr = 0;
    req = 4'b0010;
    run_xfer(4, 1, 1'b0, a_lat, d_r, d_ok, k_lat, r_lat, d_d, g_obs, g1, idl);
    n_checks++; if (g_obs !== 4'b0010) $display("FAIL areset_post_grant: got %b expected 0010", g_obs); else n_pass++;
    n_checks++; if (d_r !== 3'b110) $display("FAIL areset_post_data: got %b expected 110", d_r); else n_pass++;
    req = 4'd0;
  endtask

  task automatic test_stale_ack();
    int cnt;
    apply_reset();
    req_data = 12'h005;
    link_ack = 1'b1;
    repeat (3) @(negedge clk);
    req = 4'b0001;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (link_request !== 1'b1 && cnt < 50);
    cnt = 0;
    while (link_request === 1'b1 && cnt < 50) begin cnt++; @(negedge clk); end
    n_checks++; if (cnt !== 1) $display("FAIL stale_req_len: got %0d expected 1", cnt); else n_pass++;
    n_checks++; if (link_valid !== 1'b1 || link_data !== 3'b101) $display("FAIL stale_send: got valid=%b data=%b expected 1 101", link_valid, link_data); else n_pass++;
    link_ack = 1'b0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (link_valid !== 1'b0 && cnt < 50);
    n_checks++; if (cnt !== 3) $display("FAIL stale_rel_lat: got %0d expected 3", cnt); else n_pass++;
    n_checks++; if (grant !== 4'b0001) $display("FAIL stale_grant: got %b expected 0001", grant); else n_pass++;
    req = 4'd0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int w;
    logic [3:0] e;
    logic [3:0] r;
    bit drop;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      r = 4'($urandom_range(1, 15));
      req_data = 12'($urandom);
      req = r;
      drop = 1'($urandom_range(0, 1));
      w = pick_winner(r, m_rr);
      e = 4'b0001 << w;
      run_xfer($urandom_range(0, 10), $urandom_range(0, 6), drop, a_lat, d_r, d_ok, k_lat, r_lat, d_d, g_obs, g1, idl);
      n_checks++; if (g_obs !== e) $display("FAIL rand_grant[%0d]: got %b expected %b", i, g_obs, e); else n_pass++;
      n_checks++; if (d_r !== field(req_data, w)) $display("FAIL rand_data[%0d]: got %b expected %b", i, d_r, field(req_data, w)); else n_pass++;
      n_checks++; if (d_ok !== 1'b1 || k_lat !== 3 || r_lat !== 3) $display("FAIL rand_hs[%0d]: got stable=%b ack=%0d rel=%0d expected 1 3 3", i, d_ok, k_lat, r_lat); else n_pass++;
      m_rr = (w + 1) % 4;
      n_checks++; if (dbg_rr_ptr !== 2'(m_rr) || g1 !== 1'b1 || idl !== 1'b1) $display("FAIL rand_after[%0d]: got rr=%0d once=%b idle=%b expected %0d 1 1", i, dbg_rr_ptr, g1, idl, m_rr); else n_pass++;
    end
    req = 4'd0;
  endtask

  // test sequence and final report
  initial begin
    rst_n = 1'b0; req = 4'd0; req_data = 12'd0; link_ack = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout_req();
    test_timeout_send();
    test_async_reset();
    test_stale_ack();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
